// File: rtl/mult_acc_pkg.sv
// Shared types, defaults and the saturating-add helper for the product accumulator.
package mult_acc_pkg;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH = 24;

    // Wide enough that acc + sext(in) can never overflow before clamping.
    localparam int CALC_W = 64;

    // Clamp bounds for the default accumulator width.
    localparam logic signed [CALC_W-1:0] ACC_MAX = (64'sd1 <<< (DEF_ACC_WIDTH - 1)) - 64'sd1;
    localparam logic signed [CALC_W-1:0] ACC_MIN = -(64'sd1 <<< (DEF_ACC_WIDTH - 1));

    // ACCUM collects terms; HOLD means a result is presented (out_valid).
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic                     clamp;
        logic signed [CALC_W-1:0] sum;
    } sat_res_t;

    // Adds two already sign-extended operands and, when saturate is set,
    // clamps to the signed range of an acc_w-bit register.
    function automatic sat_res_t sat_add(
        input logic signed [CALC_W-1:0] acc,
        input logic signed [CALC_W-1:0] sext_in,
        input int                       acc_w,
        input logic                     saturate
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        logic signed [CALC_W-1:0] s;
        sat_res_t                 r;
        hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        s       = acc + sext_in;
        r.clamp = 1'b0;
        r.sum   = s;
        if (saturate) begin
            if (s > hi) begin
                r.sum   = hi;
                r.clamp = 1'b1;
            end else if (s < lo) begin
                r.sum   = lo;
                r.clamp = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_int8b_acc_if.sv
// Product input stream, result output stream and batch-abort for the accumulator.
interface mult_int8b_acc_if
    import mult_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) ();

    logic                        clr;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_ready;
    logic                        out_valid;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        out_sat;
    logic                        out_ready;

    // Producer of products / consumer of results.
    modport master (
        output clr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // The accumulator itself.
    modport slave (
        input  clr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/acc_sat_add.sv
// Combinational sign-extend, add and optional clamp of one product onto the running sum.
module acc_sat_add
    import mult_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SATURATE  = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        clamp
);

    sat_res_t res;

    // In wrap mode the low ACC_WIDTH bits of the wide sum are the modular result.
    always_comb begin
        res   = sat_add(CALC_W'(acc), CALC_W'(in_data), ACC_WIDTH, SATURATE != 0);
        sum   = res.sum[ACC_WIDTH-1:0];
        clamp = res.clamp;
    end

endmodule

// File: rtl/mult_int8b_acc.sv
// Accumulates NUM_TERMS signed products into one dot-product result with
// valid/ready on both sides, optional saturation and a per-batch sticky flag.
module mult_int8b_acc
    import mult_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_TERMS = 8,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_int8b_acc_if.slave  bus
);

    localparam int              CNT_W = $clog2(NUM_TERMS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_e                      state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_n;
    logic [CNT_W-1:0]            cnt;
    logic                        sat;
    logic                        clamp_now;
    logic signed [ACC_WIDTH-1:0] out_data_q;
    logic                        out_sat_q;
    logic                        accept;
    logic                        final_term;

    acc_sat_add #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .acc     (acc),
        .in_data (bus.in_data),
        .sum     (acc_n),
        .clamp   (clamp_now)
    );

    // A held result blocks input unless it is being drained this same cycle,
    // which lets a new result replace the old one without a bubble.
    assign bus.in_ready  = (state == ST_ACCUM || bus.out_ready) && !bus.clr;
    assign accept        = bus.in_valid && bus.in_ready;
    assign final_term    = accept && (cnt == LAST);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    // Batch accumulation, result register and ACCUM/HOLD state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACCUM;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            if (bus.clr) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end else if (final_term) begin
                acc        <= '0;
                cnt        <= '0;
                sat        <= 1'b0;
                out_data_q <= acc_n;
                out_sat_q  <= sat | clamp_now;
            end else if (accept) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
                sat <= sat | clamp_now;
            end

            case (state)
                ST_ACCUM: if (final_term) state <= ST_HOLD;
                ST_HOLD:  if (bus.out_ready && !final_term) state <= ST_ACCUM;
                default:  state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_int8b_acc.sv
// Directed bench for mult_int8b_acc: default config, 18-bit saturating and
// wrapping configs, and the single-term full-throughput config.
module tb_mult_int8b_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0: 24b/8 terms/sat, 1: 18b/8/sat, 2: 18b/8/wrap, 3: 24b/1 term/sat
    logic               clr  [4];
    logic               iv   [4];
    logic               ordy [4];
    logic signed [15:0] d    [4];
    logic               rdy  [4];
    logic               ov   [4];
    logic               osat [4];
    logic signed [31:0] od   [4];

    int errs   = 0;
    int checks = 0;

    mult_int8b_acc_if #(.IN_WIDTH(16), .ACC_WIDTH(24)) if0 ();
    mult_int8b_acc_if #(.IN_WIDTH(16), .ACC_WIDTH(18)) if1 ();
    mult_int8b_acc_if #(.IN_WIDTH(16), .ACC_WIDTH(18)) if2 ();
    mult_int8b_acc_if #(.IN_WIDTH(16), .ACC_WIDTH(24)) if3 ();

    mult_int8b_acc #(.IN_WIDTH(16), .ACC_WIDTH(24), .NUM_TERMS(8), .SATURATE(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult_int8b_acc #(.IN_WIDTH(16), .ACC_WIDTH(18), .NUM_TERMS(8), .SATURATE(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult_int8b_acc #(.IN_WIDTH(16), .ACC_WIDTH(18), .NUM_TERMS(8), .SATURATE(0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mult_int8b_acc #(.IN_WIDTH(16), .ACC_WIDTH(24), .NUM_TERMS(1), .SATURATE(1))
        u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.clr = clr[0]; assign if0.in_valid = iv[0]; assign if0.in_data = d[0]; assign if0.out_ready = ordy[0];
    assign if1.clr = clr[1]; assign if1.in_valid = iv[1]; assign if1.in_data = d[1]; assign if1.out_ready = ordy[1];
    assign if2.clr = clr[2]; assign if2.in_valid = iv[2]; assign if2.in_data = d[2]; assign if2.out_ready = ordy[2];
    assign if3.clr = clr[3]; assign if3.in_valid = iv[3]; assign if3.in_data = d[3]; assign if3.out_ready = ordy[3];

    assign rdy[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign osat[0] = if0.out_sat;
    assign rdy[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign osat[1] = if1.out_sat;
    assign rdy[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign osat[2] = if2.out_sat;
    assign rdy[3] = if3.in_ready; assign ov[3] = if3.out_valid; assign osat[3] = if3.out_sat;
    assign od[0] = {{8{if0.out_data[23]}},  if0.out_data};
    assign od[1] = {{14{if1.out_data[17]}}, if1.out_data};
    assign od[2] = {{14{if2.out_data[17]}}, if2.out_data};
    assign od[3] = {{8{if3.out_data[23]}},  if3.out_data};

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes n copies of val into instance k, waiting (bounded) for in_ready.
    task automatic push(input int k, input int val, input int n);
        for (int i = 0; i < n; i++) begin
            iv[k] = 1'b1;
            d[k]  = 16'(val);
            #1;
            for (int w = 0; w < 20 && !rdy[k]; w++) step();
            if (!rdy[k]) chk("push_timeout", 0, 1);
            step();
        end
        iv[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int vals [4] = '{-16256, 16129, 0, -1};
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b1; d[k] = '0;
        end
        #1;
        chk("rst_valid", ov[0], 0);
        chk("rst_data",  od[0], 0);
        chk("rst_sat",   osat[0], 0);
        chk("rst_ready", rdy[0], 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // 8 x +1000
        for (int i = 0; i < 8; i++) begin
            push(0, 1000, 1);
            if (i == 6) chk("t1_early_valid", ov[0], 0);
        end
        chk("t1_valid", ov[0], 1);
        chk("t1_data",  od[0], 8000);
        chk("t1_sat",   osat[0], 0);
        step();
        chk("t1_one_cycle", ov[0], 0);

        // 18-bit saturating
        push(1, 32767, 8);
        chk("sat_pos_valid", ov[1], 1);
        chk("sat_pos_data",  od[1], 131071);
        chk("sat_pos_flag",  osat[1], 1);
        push(1, -32768, 8);
        chk("sat_neg_data",  od[1], -131072);
        chk("sat_neg_flag",  osat[1], 1);
        for (int i = 0; i < 4; i++) begin
            push(1, 32767, 1);
            push(1, -32768, 1);
        end
        chk("sat_mix_data", od[1], -4);
        chk("sat_mix_flag", osat[1], 0);

        // 18-bit wrapping
        push(2, 32767, 8);
        chk("wrap_pos_data", od[2], -8);
        chk("wrap_pos_flag", osat[2], 0);
        push(2, -20000, 8);
        chk("wrap_neg_data", od[2], 102144);
        chk("wrap_neg_flag", osat[2], 0);
        step();

        // Backpressure: result held, input stalled
        ordy[0] = 1'b0;
        push(0, 10, 8);
        chk("stall_valid", ov[0], 1);
        chk("stall_data0", od[0], 80);
        iv[0] = 1'b1;
        d[0]  = 16'sd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", rdy[0], 0);
            chk("stall_hold_valid", ov[0], 1);
            chk("stall_hold_data", od[0], 80);
            step();
        end
        ordy[0] = 1'b1;
        #1;
        chk("drain_ready", rdy[0], 1);
        step();
        iv[0] = 1'b0;
        chk("drain_valid", ov[0], 0);
        push(0, 5, 7);
        chk("drain_term_kept", od[0], 40);
        step();

        // clr drops partial sum and the concurrent term
        push(0, 500, 3);
        clr[0] = 1'b1;
        iv[0]  = 1'b1;
        d[0]   = 16'sd500;
        #1;
        chk("clr_ready", rdy[0], 0);
        step();
        clr[0] = 1'b0;
        iv[0]  = 1'b0;
        push(0, 1, 8);
        chk("clr_data", od[0], 8);
        chk("clr_sat",  osat[0], 0);
        step();

        // Async reset mid-batch, with a pending result on instance 1
        ordy[1] = 1'b0;
        push(1, 1, 8);
        chk("pend_valid", ov[1], 1);
        push(0, 100, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid0", ov[0], 0);
        chk("arst_data0",  od[0], 0);
        chk("arst_valid1", ov[1], 0);
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[1] = 1'b1;
        step();
        push(0, -7, 8);
        chk("arst_batch", od[0], -56);
        step();

        // Single term: one result per cycle
        iv[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[3] = 16'(vals[i]);
            #1;
            chk("n1_ready", rdy[3], 1);
            step();
            chk("n1_valid", ov[3], 1);
            chk("n1_data",  od[3], vals[i]);
        end
        iv[3] = 1'b0;
        step();
        chk("n1_idle", ov[3], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
